// File: rtl/nibble_add_seq.sv
// nibble_add_seq: WIDTH-bit adder built from one shared 4-bit ripple adder.
// One nibble is added per clock, least-significant nibble first, with the
// carry chained between passes through the cy register. A start/done
// handshake frames each operation; busy covers the nibble passes.

// add4bit: combinational 4-bit ripple-carry adder used as the shared datapath.
module add4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] c;

    // Ripple the carry through four full-adder bit slices.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < 4; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[4];
    end

endmodule

module nibble_add_seq #(
    parameter int WIDTH   = 16,
    parameter int NIBBLES = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    // idx needs at least one bit even when there is only a single nibble.
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic             cy;
    logic [IDX_W-1:0] idx;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       add_s;
    logic             add_co;

    logic             accept;
    logic             last_pass;

    // A request is only taken when no operation is in flight; start in RUN is dropped.
    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_pass = (state == RUN) && (idx == LAST_IDX);

    // Status outputs decode straight from the state register.
    assign busy = (state == RUN);
    assign done = (state == DONE);

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE waits, RUN walks the nibbles, DONE lasts one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Pick the operand nibbles selected by idx to feed the shared adder.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx == IDX_W'(n)) begin
                a_nib = a_q[4*n +: 4];
                b_nib = b_q[4*n +: 4];
            end
        end
    end

    add4bit u_add4bit (
        .a  (a_nib),
        .b  (b_nib),
        .ci (cy),
        .s  (add_s),
        .co (add_co)
    );

    // Merge the current adder nibble into the partial result so the final
    // pass can copy the complete sum into the output register on the same edge.
    always_comb begin
        acc_nxt = acc;
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx == IDX_W'(n)) begin
                acc_nxt[4*n +: 4] = add_s;
            end
        end
    end

    // Datapath registers: latch operands on accept, accumulate one nibble per
    // RUN cycle, and publish sum/c_out only on the edge into DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            cy    <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
        end else begin
            if (accept) begin
                a_q <= a;
                b_q <= b;
                cy  <= c_in;
                idx <= '0;
            end else if (state == RUN) begin
                acc <= acc_nxt;
                cy  <= add_co;
                if (!last_pass) begin
                    idx <= idx + IDX_W'(1);
                end
            end
            if (last_pass) begin
                sum   <= acc_nxt;
                c_out <= add_co;
            end
        end
    end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Testbench for nibble_add_seq (WIDTH=16): directed vector table, multi-cycle
// corner sequences and a randomized back-to-back sweep against a plain
// arithmetic reference model.
module tb_nibble_add_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        c_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] exp_sum;
        logic        exp_co;
    } vec_t;

    vec_t vecs[8];

    nibble_add_seq #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something stalls beyond every bounded loop.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] ai, input logic [15:0] bi, input logic ci);
        a     = ai;
        b     = bi;
        c_in  = ci;
        start = 1'b1;
    endtask

    // One operation from IDLE, observed for 10 cycles after the start cycle.
    // With poke set, operands change and start pulses during RUN.
    task automatic runOp(input logic [15:0] ai, input logic [15:0] bi, input logic ci, input bit poke,
                         output int lat, output int busy_cnt, output int done_cnt,
                         output logic [15:0] s_got, output logic co_got);
        applyStimulus(ai, bi, ci);
        lat      = 0;
        busy_cnt = 0;
        done_cnt = 0;
        s_got    = '0;
        co_got   = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (poke && k == 2) begin
                a     = 16'hAAAA;
                b     = 16'hAAAA;
                c_in  = 1'b1;
                start = 1'b1;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat == 0) begin
                    lat    = k;
                    s_got  = sum;
                    co_got = c_out;
                end
            end
            checkOutput("busy_done_excl", 32'(busy & done), 32'd0);
        end
    endtask

    // Main sequence.
    initial begin
        int          lat;
        int          bcnt;
        int          dcnt;
        logic [15:0] s_got;
        logic        co_got;
        int          first_k;
        int          second_k;
        logic [15:0] s1;
        logic [15:0] s2;
        logic        c1;
        logic        c2;
        logic [16:0] exp_q[$];
        logic [16:0] exp_v;
        int          cyc;
        int          last_done;
        int          issued;
        int          retired;

        vecs[0] = '{"basic",       16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{"ripple_p1",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{"ripple_all",  16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[3] = '{"zero",        16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[4] = '{"cin_only",    16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        vecs[5] = '{"mid_carry",   16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
        vecs[6] = '{"top_carry",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
        vecs[7] = '{"nibble_cin",  16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy",  32'(busy),  32'd0);
        checkOutput("reset_done",  32'(done),  32'd0);
        checkOutput("reset_sum",   32'(sum),   32'd0);
        checkOutput("reset_c_out", 32'(c_out), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            runOp(vecs[i].a, vecs[i].b, vecs[i].ci, 1'b0, lat, bcnt, dcnt, s_got, co_got);
            checkOutput({vecs[i].name, "_latency"},  32'(lat),    32'd5);
            checkOutput({vecs[i].name, "_busy_len"}, 32'(bcnt),   32'd4);
            checkOutput({vecs[i].name, "_done_cnt"}, 32'(dcnt),   32'd1);
            checkOutput({vecs[i].name, "_sum"},      32'(s_got),  32'(vecs[i].exp_sum));
            checkOutput({vecs[i].name, "_c_out"},    32'(co_got), 32'(vecs[i].exp_co));
            checkOutput({vecs[i].name, "_sum_hold"}, 32'(sum),    32'(vecs[i].exp_sum));
        end

        // Operand changes and a start pulse during RUN must not disturb the result.
        runOp(16'h00F0, 16'h0010, 1'b0, 1'b1, lat, bcnt, dcnt, s_got, co_got);
        checkOutput("iso_latency",  32'(lat),    32'd5);
        checkOutput("iso_busy_len", 32'(bcnt),   32'd4);
        checkOutput("iso_done_cnt", 32'(dcnt),   32'd1);
        checkOutput("iso_sum",      32'(s_got),  32'h0100);
        checkOutput("iso_c_out",    32'(co_got), 32'd0);

        // Back-to-back: next operands presented in the DONE cycle with start held.
        applyStimulus(16'h8000, 16'h8000, 1'b0);
        first_k  = 0;
        second_k = 0;
        s1 = '0; s2 = '0; c1 = 1'b0; c2 = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (first_k == 0) begin
                    first_k = k;
                    s1 = sum;
                    c1 = c_out;
                    applyStimulus(16'h0001, 16'h0002, 1'b1);
                end else if (second_k == 0) begin
                    second_k = k;
                    s2 = sum;
                    c2 = c_out;
                    start = 1'b0;
                end
            end
        end
        checkOutput("b2b_first_lat",  32'(first_k),  32'd5);
        checkOutput("b2b_second_lat", 32'(second_k), 32'd10);
        checkOutput("b2b_sum1",       32'(s1),       32'h0000);
        checkOutput("b2b_c_out1",     32'(c1),       32'd1);
        checkOutput("b2b_sum2",       32'(s2),       32'h0004);
        checkOutput("b2b_c_out2",     32'(c2),       32'd0);

        // Put a nonzero result in sum/c_out so the mid-op reset has something to clear.
        runOp(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, lat, bcnt, dcnt, s_got, co_got);
        checkOutput("pre_rst_sum", 32'(s_got), 32'hFFFE);

        // Reset asserted during the second RUN cycle.
        applyStimulus(16'h1111, 16'h2222, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        checkOutput("rst_mid_busy",  32'(busy),  32'd0);
        checkOutput("rst_mid_done",  32'(done),  32'd0);
        checkOutput("rst_mid_sum",   32'(sum),   32'd0);
        checkOutput("rst_mid_c_out", 32'(c_out), 32'd0);
        dcnt = 0;
        bcnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
            if (busy) bcnt++;
        end
        checkOutput("rst_mid_no_done", 32'(dcnt), 32'd0);
        checkOutput("rst_mid_no_busy", 32'(bcnt), 32'd0);
        runOp(16'h1111, 16'h2222, 1'b0, 1'b0, lat, bcnt, dcnt, s_got, co_got);
        checkOutput("post_rst_latency", 32'(lat),    32'd5);
        checkOutput("post_rst_sum",     32'(s_got),  32'h3333);
        checkOutput("post_rst_c_out",   32'(co_got), 32'd0);

        // Randomized back-to-back sweep; operands are scrambled while busy.
        a     = 16'($urandom);
        b     = 16'($urandom);
        c_in  = 1'($urandom_range(0, 1));
        start = 1'b1;
        exp_q.push_back(17'(a) + 17'(b) + 17'(c_in));
        issued    = 1;
        retired   = 0;
        cyc       = 0;
        last_done = -1;
        while (retired < 1000 && cyc < 6000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    checkOutput("rand_unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_v = exp_q.pop_front();
                    checkOutput("rand_sum",   32'(sum),   32'(exp_v[15:0]));
                    checkOutput("rand_c_out", 32'(c_out), 32'(exp_v[16]));
                end
                if (last_done >= 0) begin
                    checkOutput("rand_spacing", 32'(cyc - last_done), 32'd5);
                end
                last_done = cyc;
                retired++;
                if (issued < 1000) begin
                    a    = 16'($urandom);
                    b    = 16'($urandom);
                    c_in = 1'($urandom_range(0, 1));
                    exp_q.push_back(17'(a) + 17'(b) + 17'(c_in));
                    issued++;
                end else begin
                    start = 1'b0;
                end
            end else begin
                a    = 16'($urandom);
                b    = 16'($urandom);
                c_in = 1'($urandom_range(0, 1));
            end
        end
        start = 1'b0;
        checkOutput("rand_retired", 32'(retired), 32'd1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_add_seq.md
# nibble_add_seq

Sequencer that performs WIDTH-bit additions using a single shared 4-bit ripple adder (`add4bit`), one nibble per clock, least-significant nibble first. The carry is chained between nibbles through an internal register. The block sits between a requester using a start/done handshake and the combinational `add4bit` datapath, which it instantiates internally. It trades latency for area wherever a wide adder is not justified.

## Interface

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived; number of adder passes. Do not override.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request. Accepted only in IDLE or DONE state.
- a  input  WIDTH  operand A. Sampled on the accepted start.
- b  input  WIDTH  operand B. Sampled on the accepted start.
- c_in  input  1  carry into nibble 0. Sampled on the accepted start.
- busy  output  1  high while nibbles are being processed.
- done  output  1  one-cycle pulse; sum and c_out are valid and new in this cycle.
- sum  output  WIDTH  registered result. Holds until the next completion.
- c_out  output  1  registered carry out of the top nibble. Holds until the next completion.

## Operation

- Internal state: operand registers a_q and b_q (WIDTH each), carry register cy, nibble counter idx (width clog2(NIBBLES), minimum 1), partial-result register acc (WIDTH), and a FSM.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1: latch a, b and c_in into a_q, b_q and cy; clear idx to 0; go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - Drive `add4bit` with a_q[4*idx+:4], b_q[4*idx+:4] and cy.
  - At the clock edge: write the adder sum into acc[4*idx+:4] and write the adder carry into cy.
  - If idx==NIBBLES-1, go to DONE. Otherwise increment idx.
- Entering DONE: copy acc (including the final nibble) into sum, and the final carry into c_out.
- DONE:
  - done=1 for exactly this cycle.
  - start=1: accepted exactly as in IDLE; go to RUN (back-to-back operation).
  - start=0: go to IDLE.
- start in RUN is ignored. It has no effect and is not queued.
- a, b and c_in are don't-care outside the cycle where start is accepted. Changing them mid-operation must not affect the result.
- Arithmetic: {c_out, sum} = a + b + c_in, modulo 2^(WIDTH+1). No overflow flag is produced.
- The result is identical to a WIDTH-bit ripple adder; only the latency differs.

## Timing

- Reset (rst=1 at a clock edge, from any state, including mid-RUN):
  - Next cycle: state=IDLE, busy=0, done=0, sum=0, c_out=0, idx=0, cy=0.
  - Any in-flight operation is abandoned; no done pulse is issued for it.
  - If rst and start are both high in the same cycle, rst wins.
- Start is accepted at edge T, with start high in cycle T-1 while in IDLE or DONE.
  - busy is high for cycles T through T+NIBBLES-1 (NIBBLES cycles).
  - done and the updated sum/c_out appear in cycle T+NIBBLES.
  - Latency from the start cycle to the done cycle is NIBBLES+1 cycles. For WIDTH=16 this is 5 cycles.
- busy and done are never high simultaneously.
- busy is combinationally equal to (state==RUN) and is registered via the state register.
- Back-to-back: start held high continuously gives one result every NIBBLES+1 cycles.
- WIDTH=4 (NIBBLES=1): RUN lasts one cycle. idx stays 0.
- sum and c_out change only on the edge into DONE or on reset. They are stable at all other times.

## Test plan

All scenarios use WIDTH=16.

- Basic add: reset, then start with a=0x1234, b=0x4321, c_in=0 -> busy high for 4 cycles; done in cycle 5 after start; sum=0x5555, c_out=0.
- Full carry ripple: a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1. Then a=0xFFFF, b=0xFFFF, c_in=1 -> sum=0xFFFF, c_out=1.
- Input and start isolation: start with a=0x00F0, b=0x0010, c_in=0; during RUN, change a/b to 0xAAAA and pulse start -> sum=0x0100, c_out=0; exactly one done pulse; busy length unaffected.
- Back-to-back: hold start high with a=0x8000, b=0x8000, c_in=0, then a=0x0001, b=0x0002, c_in=1 presented in the DONE cycle -> first done gives sum=0x0000, c_out=1; second done exactly 5 cycles later gives sum=0x0004, c_out=0.
- Reset mid-op: start with a=0x1111, b=0x2222, c_in=0; assert rst in the second RUN cycle -> next cycle busy=0, done=0, sum=0x0000, c_out=0; no done pulse follows. A new start after reset completes normally.
- Randomized sweep: 1000 random {a, b, c_in} -> {c_out, sum} matches a+b+c_in; done spacing is exactly 5 cycles when start is held high.
